i2c_arbiter: RTL

Round-robin arbiter and transaction sequencer that shares one `mod_I2C` master between up to `N_REQ` requesters. It sits between the requesters (APB-side register blocks, sensor pollers) and the master's `command`/`dataIn`/`dataOut` word interface. It grants one requester at a time and formats that requester's transfer into the master's words. It issues the start pulse, supervises completion with a timeout, resets the master on a hang, and returns read data and status to the granted requester.

---
 rtl/i2c_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/i2c_arbiter.sv
// i2c_arbiter: round-robin share of one mod_I2C master between N_REQ
// requesters; builds command/dataIn words, supervises start/ready, times out.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req, req_rnw, req_speed  per-requester request level, read flag, speed
//   req_addr, req_wdata      packed 7-bit addresses / 8-bit write bytes
//   gnt, done, err           one-hot grant, one-cycle done, error pulse
//   rdata, busy              last read byte, not-idle flag
//   command, dataIn          words to the master
//   dataOut                  master status: [7:0] read byte, [8] ready
module i2c_arbiter #(
  parameter int N_REQ      = 4,
  parameter int TIMEOUT    = 65535,
  parameter int ACCEPT_CYC = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   req_rnw,
  input  logic [7*N_REQ-1:0] req_addr,
  input  logic [8*N_REQ-1:0] req_wdata,
  input  logic [N_REQ-1:0]   req_speed,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic               err,
  output logic [7:0]         rdata,
  output logic               busy,
  output logic [31:0]        command,
  output logic [31:0]        dataIn,
  input  logic [31:0]        dataOut
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WACC,
    S_WDONE,
    S_COMPL,
    S_ABORT
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [IW-1:0]   cur_q, last_q;
  logic            rnw_q, speed_q;
  logic [6:0]      addr_q;
  logic [7:0]      wdata_q;
  logic [7:0]      rdata_q;

  logic            rdy;
  logic            act;
  logic            fin;
  logic            win_vld;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   idx;
  logic            w_rnw, w_speed;
  logic [6:0]      w_addr;
  logic [7:0]      w_wdata;
  logic [N_REQ-1:0] cur_oh;
  logic            unused_dout;

  assign rdy         = dataOut[8];
  assign unused_dout = ^dataOut[31:9];

  // Scan from last+k, k = N_REQ down to 1, so the smallest k that has a
  // request is written last and wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    idx     = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = IW'((int'(last_q) + k) % N_REQ);
      if (req[idx]) begin
        win_vld = 1'b1;
        win_idx = idx;
      end
    end
  end

  always_comb begin
    w_rnw   = 1'b0;
    w_speed = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == IW'(i)) begin
        w_rnw   = req_rnw[i];
        w_speed = req_speed[i];
        w_addr  = req_addr[i*7 +: 7];
        w_wdata = req_wdata[i*8 +: 8];
      end
    end
  end

  // Ready wins over the counter limit on the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE:  if (win_vld) state_d = S_LOAD;
      S_LOAD:  state_d = S_START;
      S_START: begin
        state_d = S_WACC;
        cnt_d   = '0;
      end
      S_WACC: begin
        if (!rdy) begin
          state_d = S_WDONE;
          cnt_d   = '0;
        end else if (cnt_q == 16'(ACCEPT_CYC - 1)) begin
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WDONE: begin
        if (rdy) begin
          state_d = S_COMPL;
        end else if (cnt_q == 16'(TIMEOUT - 1)) begin
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_COMPL: state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cur_q   <= '0;
      last_q  <= IW'(N_REQ - 1);
      rnw_q   <= 1'b0;
      speed_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && win_vld) begin
        cur_q   <= win_idx;
        rnw_q   <= w_rnw;
        speed_q <= w_speed;
        addr_q  <= w_addr;
        wdata_q <= w_wdata;
      end
      if (state_q == S_WDONE && rdy && rnw_q) begin
        rdata_q <= dataOut[7:0];
      end
      if (fin) begin
        last_q <= cur_q;
      end
    end
  end

  assign act    = (state_q != S_IDLE);
  assign fin    = (state_q == S_COMPL) || (state_q == S_ABORT);
  assign cur_oh = {{(N_REQ-1){1'b0}}, 1'b1} << cur_q;

  assign busy    = act;
  assign gnt     = act ? cur_oh : '0;
  assign done    = fin ? cur_oh : '0;
  assign err     = (state_q == S_ABORT);
  assign rdata   = rdata_q;
  assign command = {29'b0, act & speed_q,
                    state_q == S_ABORT, state_q == S_START};
  assign dataIn  = act ? {16'b0, wdata_q, addr_q, rnw_q} : 32'b0;

endmodule
